// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor slice.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle between the operand source, the subtractor
// and the result consumer.
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             zero;

  // Source/consumer side: presents operands and accepts results.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, d, bout, zero
  );

  // Subtractor side.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, d, bout, zero
  );

endinterface

// File: rtl/serial_subtractor_sub_bit_cell.sv
// Combinational 1-bit full subtractor: di = ai - bi - br, with borrow out.
module sub_bit_cell (
  input  logic ai,
  input  logic bi,
  input  logic br,
  output logic di,
  output logic br_next
);

  assign di      = ai ^ bi ^ br;
  assign br_next = (~ai & bi) | (~(ai ^ bi) & br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: D = A - B, LSB first, one bit per clock,
// through a single reused 1-bit subtract cell and a registered borrow.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus,
  output logic                 busy
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             bout_r;
  logic             zero_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             di;
  logic             br_next;

  // The one subtract cell, fed from the current operand LSBs and borrow.
  sub_bit_cell u_cell (
    .ai      (sh_a[0]),
    .bi      (sh_b[0]),
    .br      (br),
    .di      (di),
    .br_next (br_next)
  );

  // Result after this cycle's bit enters at the MSB.
  assign res_next = {di, res[WIDTH-1:1]};

  // Control FSM and datapath; every output is a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the operand/result registers are plain flops, not a memory
      // array, so they are reset with everything else at no extra cost.
      state       <= IDLE;
      sh_a        <= '0;
      sh_b        <= '0;
      res         <= '0;
      cnt         <= '0;
      br          <= 1'b0;
      bout_r      <= 1'b0;
      zero_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every read below
      // sees the pre-edge value regardless of statement order.
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            sh_a       <= bus.a;
            sh_b       <= bus.b;
            res        <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          res  <= res_next;
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            bout_r      <= br_next;
            zero_r      <= (res_next == '0);
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            zero_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.d         = res;
  assign bus.bout      = bout_r;
  assign bus.zero      = zero_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: table of operand pairs with
// hand-computed results, plus backpressure, scrambled-input and
// mid-transaction reset sequences.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bout;
    logic         zero;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One full transaction. stall = cycles out_ready stays low after out_valid;
  // scramble = keep in_valid high and change a/b during SHIFT.
  task automatic run_vec(input vec_t v, input int stall, input bit scramble);
    int n;
    int busy_n;
    bit seen;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_idle", 32'(bus.in_ready), 1);
    bus.a         = v.a;
    bus.b         = v.b;
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    @(posedge clk); #1;                       // accept edge (edge 0)
    check("in_ready_shift", 32'(bus.in_ready), 0);
    busy_n = busy ? 1 : 0;
    n      = 0;
    seen   = 1'b0;
    while (!seen && n < 50) begin
      if (scramble) begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1; n++;
      if (busy) busy_n++;
      seen = bus.out_valid;
    end
    bus.in_valid = 1'b0;
    check("latency", 32'(n), 32'(W));
    check("d", 32'(bus.d), 32'(v.d));
    check("bout", 32'(bus.bout), 32'(v.bout));
    check("zero", 32'(bus.zero), 32'(v.zero));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (busy) busy_n++;
      check("hold_d", 32'(bus.d), 32'(v.d));
      check("hold_out_valid", 32'(bus.out_valid), 1);
      check("hold_in_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", 32'(bus.out_valid), 0);
    check("release_in_ready", 32'(bus.in_ready), 1);
    check("release_busy", 32'(busy), 0);
    check("release_zero", 32'(bus.zero), 0);
    check("busy_cycles", 32'(busy_n), 32'(W + 1 + stall));
  endtask

  initial begin
    vec_t vecs[7];
    vec_t v;

    vecs[0] = '{a: 8'd200, b: 8'd55,  d: 8'd145, bout: 1'b0, zero: 1'b0};
    vecs[1] = '{a: 8'd5,   b: 8'd10,  d: 8'd251, bout: 1'b1, zero: 1'b0};
    vecs[2] = '{a: 8'd0,   b: 8'd1,   d: 8'd255, bout: 1'b1, zero: 1'b0};
    vecs[3] = '{a: 8'd255, b: 8'd255, d: 8'd0,   bout: 1'b0, zero: 1'b1};
    vecs[4] = '{a: 8'd128, b: 8'd129, d: 8'd255, bout: 1'b1, zero: 1'b0};
    vecs[5] = '{a: 8'd1,   b: 8'd0,   d: 8'd1,   bout: 1'b0, zero: 1'b0};
    vecs[6] = '{a: 8'd170, b: 8'd85,  d: 8'd85,  bout: 1'b0, zero: 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_d", 32'(bus.d), 0);
    check("rst_bout", 32'(bus.bout), 0);
    check("rst_zero", 32'(bus.zero), 0);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors back to back with out_ready held high.
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], 0, 1'b0);
    end

    // Backpressure: result must hold for 5 cycles with out_ready low.
    v = '{a: 8'd100, b: 8'd1, d: 8'd99, bout: 1'b0, zero: 1'b0};
    run_vec(v, 5, 1'b0);

    // in_valid kept high with changing operands during SHIFT.
    v = '{a: 8'd60, b: 8'd70, d: 8'd246, bout: 1'b1, zero: 1'b0};
    run_vec(v, 0, 1'b1);

    // Reset at edge 3 of a transaction aborts it.
    bus.a        = 8'd170;
    bus.b        = 8'd85;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;                       // edge 0 (accept)
    bus.in_valid = 1'b0;
    check("abort_busy_before", 32'(busy), 1);
    @(posedge clk);                           // edge 1
    @(posedge clk);                           // edge 2
    @(posedge clk);                           // edge 3
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(bus.in_ready), 1);
    check("abort_out_valid", 32'(bus.out_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_d", 32'(bus.d), 0);
    check("abort_bout", 32'(bus.bout), 0);
    check("abort_zero", 32'(bus.zero), 0);
    @(negedge clk);
    rst = 1'b0;
    v = '{a: 8'd9, b: 8'd3, d: 8'd6, bout: 1'b0, zero: 1'b0};
    run_vec(v, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
